hazard_ctrl: RTL

Central pipeline hazard controller for the 5-stage core. It generates the stall and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It covers load-use hazards (with a configurable bubble count), taken-branch/jump redirects from EX, multi-cycle data-memory busy, and program halt. It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush generation for load-use, EX redirects,
// data-memory busy and halt, plus a saturating stall-cycle counter.
module hazard_ctrl #(
   parameter int LOAD_USE_BUBBLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  id_reg1_sel,
   input  logic [2:0]  id_reg2_sel,
   input  logic        id_rs_valid,
   input  logic        id_rt_valid,
   input  logic [2:0]  ex_write_reg,
   input  logic        ex_regWrite,
   input  logic        ex_memEn,
   input  logic        ex_memWrite,
   input  logic        ex_redirect,
   input  logic        mem_busy,
   input  logic        wb_halt,
   output logic        pc_stall,
   output logic        if_id_stall,
   output logic        if_id_flush,
   output logic        id_ex_stall,
   output logic        id_ex_flush,
   output logic        ex_mem_stall,
   output logic        mem_wb_flush,
   output logic        halted,
   output logic [15:0] stall_cycles
);

   // state  | meaning
   // RUN    | normal issue; a load-use hazard here inserts the first bubble
   // BUBBLE | inserting the remaining load-use bubbles, cnt counts them down
   // HALTED | HALT retired; everything held until reset
   typedef enum logic [1:0] {
      RUN    = 2'd0,
      BUBBLE = 2'd1,
      HALTED = 2'd2
   } state_t;

   localparam logic [1:0] CNT_INIT = 2'(LOAD_USE_BUBBLES - 1);

   state_t     state, state_nxt;
   logic [1:0] cnt, cnt_nxt;
   logic       ld;

   assign ld = ex_memEn & ~ex_memWrite & ex_regWrite &
               ((id_rs_valid & (id_reg1_sel == ex_write_reg)) |
                (id_rt_valid & (id_reg2_sel == ex_write_reg)));

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_stall  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_stall = 1'b0;
      mem_wb_flush = 1'b0;

      if (state == HALTED) begin
         pc_stall     = 1'b1;
         if_id_stall  = 1'b1;
         id_ex_stall  = 1'b1;
         ex_mem_stall = 1'b1;
      end else if (mem_busy) begin
         // EX is held, so a pending redirect or hazard is simply seen again later
         pc_stall     = 1'b1;
         if_id_stall  = 1'b1;
         id_ex_stall  = 1'b1;
         ex_mem_stall = 1'b1;
         mem_wb_flush = 1'b1;
      end else if (ex_redirect) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         state_nxt   = RUN;
         cnt_nxt     = 2'd0;
      end else if (state == BUBBLE) begin
         pc_stall    = 1'b1;
         if_id_stall = 1'b1;
         id_ex_flush = 1'b1;
         if (cnt == 2'd1) begin
            state_nxt = RUN;
            cnt_nxt   = 2'd0;
         end else begin
            cnt_nxt = cnt - 2'd1;
         end
      end else if (ld) begin
         pc_stall    = 1'b1;
         if_id_stall = 1'b1;
         id_ex_flush = 1'b1;
         if (LOAD_USE_BUBBLES > 1) begin
            state_nxt = BUBBLE;
            cnt_nxt   = CNT_INIT;
         end
      end

      if (wb_halt) begin
         state_nxt = HALTED;
      end

      if (rst) begin
         pc_stall     = 1'b0;
         if_id_stall  = 1'b0;
         if_id_flush  = 1'b0;
         id_ex_stall  = 1'b0;
         id_ex_flush  = 1'b0;
         ex_mem_stall = 1'b0;
         mem_wb_flush = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= RUN;
         cnt          <= 2'd0;
         stall_cycles <= 16'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (pc_stall && (state != HALTED) && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
         end
      end
   end

   assign halted = (state == HALTED);

endmodule
